// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array weight path.
`timescale 1ns/1ps
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2,
      DRAIN  = 2'd3
   } loader_state_t;

   localparam int ARRAY_N  = 8;
   localparam int WEIGHT_W = 8;

   // Flat position of weight (r,j) in an n x n matrix.
   function automatic int unsigned mat_idx(input int unsigned r, input int unsigned j,
                                           input int unsigned n);
      return r * n + j;
   endfunction

endpackage

// File: rtl/weight_bank.sv
// N x N weight register file: per-row write, whole-matrix copy, synchronous clear.
`timescale 1ns/1ps
module weight_bank
   import systolic_pkg::*;
#(
   parameter int N = ARRAY_N,
   parameter int W = WEIGHT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   row_we,
   input  logic [$clog2(N)-1:0]   row_sel,
   input  logic [N*W-1:0]         row_data,
   input  logic                   copy_en,
   input  logic [N*N*W-1:0]       copy_data,
   output logic [N*N*W-1:0]       mat
);

   logic [N*N*W-1:0] mat_r;

   // Matrix storage; clear beats copy, copy beats a row write.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         mat_r <= {(N*N*W){1'b0}};
      end else if (copy_en) begin
         mat_r <= copy_data;
      end else if (row_we) begin
         for (int j = 0; j < N; j++) begin
            mat_r[mat_idx(32'(row_sel), j, N)*W +: W] <= row_data[j*W +: W];
         end
      end else begin
         mat_r <= mat_r;
      end
   end

   assign mat = mat_r;

endmodule

// File: rtl/weight_row_loader.sv
// Pulls N weight rows into a shadow bank, then commits them to the active bank feeding the PEs.
`timescale 1ns/1ps
module weight_row_loader
   import systolic_pkg::*;
#(
   parameter int N = ARRAY_N,
   parameter int W = WEIGHT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               w_valid,
   input  logic [N*W-1:0]     w_data,
   output logic               w_ready,
   output logic [N*N*W-1:0]   weights_out,
   output logic               commit,
   output logic               busy,
   output logic               underrun
);

   localparam int RW = $clog2(N);
   localparam int CW = RW + 1;

   loader_state_t    state_r, next_state_s;
   logic [CW-1:0]    row_cnt_r;
   logic             commit_r, underrun_r;
   logic             ready_s, busy_s, start_s, copy_s, discard_s;
   logic             xfer_s, last_row_s;
   logic [N*N*W-1:0] shadow_s;

   assign xfer_s     = w_valid && ready_s;
   assign last_row_s = (row_cnt_r == CW'(N - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; a window never loads more than one matrix.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (load) next_state_s = FILL;
            else      next_state_s = IDLE;
         end
         FILL: begin
            if (xfer_s && last_row_s) next_state_s = COMMIT;
            else if (!load)           next_state_s = IDLE;
            else                      next_state_s = FILL;
         end
         COMMIT: begin
            if (load) next_state_s = DRAIN;
            else      next_state_s = IDLE;
         end
         DRAIN: begin
            if (!load) next_state_s = IDLE;
            else       next_state_s = DRAIN;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State-decoded controls.
   always_comb begin
      ready_s   = 1'b0;
      busy_s    = 1'b0;
      start_s   = 1'b0;
      copy_s    = 1'b0;
      discard_s = 1'b0;
      case (state_r)
         IDLE:    start_s = load;
         FILL: begin
            busy_s    = 1'b1;
            ready_s   = load;
            discard_s = !load;
         end
         COMMIT: begin
            busy_s = 1'b1;
            copy_s = 1'b1;
         end
         DRAIN:   busy_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // Row counter, commit pulse and sticky underrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_r  <= {CW{1'b0}};
         commit_r   <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         commit_r <= copy_s;
         if (start_s)     row_cnt_r <= {CW{1'b0}};
         else if (xfer_s) row_cnt_r <= row_cnt_r + CW'(1);
         else             row_cnt_r <= row_cnt_r;
         if (start_s)        underrun_r <= 1'b0;
         else if (discard_s) underrun_r <= 1'b1;
         else                underrun_r <= underrun_r;
      end
   end

   weight_bank #(.N(N), .W(W)) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .clr       (discard_s),
      .row_we    (xfer_s),
      .row_sel   (row_cnt_r[RW-1:0]),
      .row_data  (w_data),
      .copy_en   (1'b0),
      .copy_data ({(N*N*W){1'b0}}),
      .mat       (shadow_s)
   );

   weight_bank #(.N(N), .W(W)) u_active (
      .clk       (clk),
      .rst       (rst),
      .clr       (1'b0),
      .row_we    (1'b0),
      .row_sel   ({RW{1'b0}}),
      .row_data  ({(N*W){1'b0}}),
      .copy_en   (copy_s),
      .copy_data (shadow_s),
      .mat       (weights_out)
   );

   assign w_ready  = ready_s;
   assign busy     = busy_s;
   assign commit   = commit_r;
   assign underrun = underrun_r;

endmodule

// File: tb/tb_weight_row_loader.sv
// Randomized scoreboard bench for weight_row_loader against a window-level reference model.
`timescale 1ns/1ps
module tb_weight_row_loader;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int MW = N*N*W;

   typedef struct {
      logic [MW-1:0] m;
      int            cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst, load, w_valid;
   logic [N*W-1:0]  w_data;
   logic            w_ready, commit, busy, underrun;
   logic [MW-1:0]   weights_out;

   exp_t            q[$];
   logic [MW-1:0]   cur_m;
   int              cyc = 0;
   int              n_cmp = 0;
   int              n_bad = 0;
   bit              started = 1'b0;

   weight_row_loader #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .load(load), .w_valid(w_valid), .w_data(w_data),
      .w_ready(w_ready), .weights_out(weights_out), .commit(commit),
      .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every commit must match the oldest queued matrix at its predicted cycle.
   always @(negedge clk) begin
      if (started && !rst) begin
         if (commit) begin
            if (q.size() == 0) begin
               chk("commit_unexpected", MW'(1), MW'(0));
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("commit_matrix", weights_out, e.m);
               chk("commit_cycle", MW'(cyc), MW'(e.cyc));
               cur_m = e.m;
            end
         end else begin
            chk("weights_hold", weights_out, cur_m);
            if (q.size() != 0 && cyc > q[0].cyc) begin
               chk("commit_missing", MW'(cyc), MW'(q[0].cyc));
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic reset_checks();
      chk("rst_weights", weights_out, MW'(0));
      chk("rst_busy", MW'(busy), MW'(0));
      chk("rst_ready", MW'(w_ready), MW'(0));
      chk("rst_underrun", MW'(underrun), MW'(0));
      chk("rst_commit", MW'(commit), MW'(0));
   endtask

   // One load window of len cycles followed by gap idle cycles; the model accepts the
   // first N offered rows after the opening cycle and expects a commit two cycles later.
   task automatic drive_window(input int len, input logic [31:0] vmask, input bit pat,
                               input int gap);
      int            acc = 0;
      logic [MW-1:0] m = '0;
      bit            exp_rdy;
      for (int idx = 0; idx < len; idx++) begin
         load    = 1'b1;
         w_valid = vmask[idx];
         for (int j = 0; j < N; j++)
            w_data[j*W +: W] = pat ? W'(acc + 1) : W'($urandom);
         @(negedge clk);
         exp_rdy = (idx >= 1) && (acc < N);
         chk("w_ready", MW'(w_ready), MW'(exp_rdy));
         chk("busy", MW'(busy), MW'(idx >= 1));
         if (idx == 1) chk("underrun_clear", MW'(underrun), MW'(0));
         if (exp_rdy && w_valid) begin
            for (int j = 0; j < N; j++)
               m[(acc*N + j)*W +: W] = w_data[j*W +: W];
            acc++;
            if (acc == N) q.push_back('{m: m, cyc: cyc + 2});
         end
         @(posedge clk); #1;
      end
      for (int g = 0; g < gap; g++) begin
         load    = 1'b0;
         w_valid = 1'($urandom);
         w_data  = {$urandom, $urandom};
         @(negedge clk);
         chk("ready_gap", MW'(w_ready), MW'(0));
         @(posedge clk); #1;
      end
      chk("underrun", MW'(underrun), MW'(acc < N));
      chk("idle_busy", MW'(busy), MW'(0));
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; w_valid = 1'b0; w_data = '0;
      cur_m = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      rst = 1'b0;
      started = 1'b1;

      // Full load with row k = k+1 everywhere.
      drive_window(9, 32'hFFFF_FFFF, 1'b1, 2);

      // Three transfers, then reset mid-fill for two cycles.
      for (int idx = 0; idx < 4; idx++) begin
         load = 1'b1; w_valid = 1'b1; w_data = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      rst = 1'b1; load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cur_m = '0;
      q.delete();
      reset_checks();
      rst = 1'b0;

      drive_window(9, 32'hFFFF_FFFF, 1'b0, 1);   // fresh full matrix after reset
      drive_window(12, ~32'h0000_0088, 1'b0, 1); // stalls on transfers 2 and 5
      drive_window(5, 32'hFFFF_FFFF, 1'b0, 1);   // underrun, active keeps prior matrix
      drive_window(15, 32'hFFFF_FFFF, 1'b0, 1);  // long window, drain
      drive_window(9, 32'hFFFF_FFFF, 1'b0, 1);   // back-to-back A
      drive_window(9, 32'hFFFF_FFFF, 1'b0, 1);   // back-to-back B

      for (int w = 0; w < 25; w++)
         drive_window(int'($urandom_range(2, 18)), $urandom | $urandom, 1'b0,
                      int'($urandom_range(1, 3)));

      load = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pending_commits", MW'(q.size()), MW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
